// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared control-word layout, RegDst codes and ID/EX FSM states
package pipeline_pkg;

  localparam int CTRL_W         = 10;
  localparam int CTRL_REGWRITE  = 9;
  localparam int CTRL_MEMREAD   = 8;
  localparam int CTRL_MEMWRITE  = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_REGDST_HI = 4;
  localparam int CTRL_REGDST_LO = 3;
  localparam int CTRL_ALUOP_HI  = 2;
  localparam int CTRL_ALUOP_LO  = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [1:0] {
    REGDST_RT     = 2'b00,
    REGDST_RD     = 2'b01,
    REGDST_RA     = 2'b10,
    REGDST_RT_ALT = 2'b11
  } regdst_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HOLD   = 2'b01,
    ST_BUBBLE = 2'b10
  } id_ex_state_e;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - EX destination decode and load-use hazard compare
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic       i_ex_regwrite,
  input  logic       i_ex_memread,
  input  logic [1:0] i_ex_regdst,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_ex_rd,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_flush,
  output logic [4:0] o_ex_regdest,
  output logic       o_hazard,
  output logic       o_hazard_stall
);

  logic [4:0] w_dest;

  always_comb begin
    w_dest = i_ex_rt;
    case (regdst_e'(i_ex_regdst))
      REGDST_RD:     w_dest = i_ex_rd;
      REGDST_RA:     w_dest = REG_RA;
      default:       w_dest = i_ex_rt;
    endcase
  end

  assign o_ex_regdest = (i_ex_valid && i_ex_regwrite) ? w_dest : REG_ZERO;

  // RegDest is already zero for non-writing instructions, so RegWrite is implied here
  assign o_hazard = i_ex_valid && i_ex_memread && (o_ex_regdest != REG_ZERO) && i_id_valid &&
                    ((o_ex_regdest == i_id_rs) || (o_ex_regdest == i_id_rt));

  assign o_hazard_stall = o_hazard && !i_flush;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with flush, external hold and load-use bubble
module id_ex_stage
  import pipeline_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [31:0]       i_id_instruction,
  input  logic [31:0]       i_id_pc_plus4,
  input  logic [31:0]       i_id_read_data1,
  input  logic [31:0]       i_id_read_data2,
  input  logic [31:0]       i_id_sign_ext,
  input  logic [CTRL_W-1:0] i_id_control,
  input  logic              i_flush,
  input  logic              i_ext_stall,
  output logic [31:0]       o_ex_instruction,
  output logic [31:0]       o_ex_pc_plus4,
  output logic [31:0]       o_ex_read_data1,
  output logic [31:0]       o_ex_read_data2,
  output logic [31:0]       o_ex_sign_ext,
  output logic [CTRL_W-1:0] o_ex_control,
  output logic              o_ex_valid,
  output logic [4:0]        o_ex_regdest,
  output logic              o_hazard_stall,
  output logic [15:0]       o_stall_count
);

  id_ex_state_e r_state, w_state_nxt;

  logic [31:0]       r_ex_instruction, r_ex_pc_plus4, r_ex_read_data1, r_ex_read_data2, r_ex_sign_ext;
  logic [CTRL_W-1:0] r_ex_control;
  logic              r_ex_valid;
  logic [15:0]       r_stall_count;
  logic              w_hazard, w_hazard_stall;

  load_use_detect u_load_use_detect (
    .i_ex_valid     (r_ex_valid),
    .i_ex_regwrite  (r_ex_control[CTRL_REGWRITE]),
    .i_ex_memread   (r_ex_control[CTRL_MEMREAD]),
    .i_ex_regdst    (r_ex_control[CTRL_REGDST_HI:CTRL_REGDST_LO]),
    .i_ex_rt        (r_ex_instruction[20:16]),
    .i_ex_rd        (r_ex_instruction[15:11]),
    .i_id_valid     (i_id_valid),
    .i_id_rs        (i_id_instruction[25:21]),
    .i_id_rt        (i_id_instruction[20:16]),
    .i_flush        (i_flush),
    .o_ex_regdest   (o_ex_regdest),
    .o_hazard       (w_hazard),
    .o_hazard_stall (w_hazard_stall)
  );

  // The next state also selects this edge's register action: HOLD keeps, BUBBLE kills control
  always_comb begin
    w_state_nxt = ST_RUN;
    if (i_flush) begin
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN, ST_HOLD: begin
          if (i_ext_stall)   w_state_nxt = ST_HOLD;
          else if (w_hazard) w_state_nxt = ST_BUBBLE;
          else               w_state_nxt = ST_RUN;
        end
        ST_BUBBLE: begin
          if (i_ext_stall)   w_state_nxt = ST_HOLD;
          else               w_state_nxt = ST_RUN;
        end
        default:             w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_valid       <= 1'b0;
      r_ex_control     <= '0;
      r_ex_instruction <= '0;
      r_ex_pc_plus4    <= '0;
      r_ex_read_data1  <= '0;
      r_ex_read_data2  <= '0;
      r_ex_sign_ext    <= '0;
    end else if (i_flush) begin
      r_ex_valid       <= 1'b0;
      r_ex_control     <= '0;
      r_ex_instruction <= '0;
      r_ex_pc_plus4    <= '0;
      r_ex_read_data1  <= '0;
      r_ex_read_data2  <= '0;
      r_ex_sign_ext    <= '0;
    end else if (w_state_nxt != ST_HOLD) begin
      if (w_state_nxt == ST_BUBBLE) begin
        r_ex_valid   <= 1'b0;
        r_ex_control <= '0;
      end else begin
        r_ex_valid   <= i_id_valid;
        r_ex_control <= i_id_valid ? i_id_control : '0;
      end
      r_ex_instruction <= i_id_instruction;
      r_ex_pc_plus4    <= i_id_pc_plus4;
      r_ex_read_data1  <= i_id_read_data1;
      r_ex_read_data2  <= i_id_read_data2;
      r_ex_sign_ext    <= i_id_sign_ext;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_count <= '0;
    end else if (w_hazard_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign o_ex_instruction = r_ex_instruction;
  assign o_ex_pc_plus4    = r_ex_pc_plus4;
  assign o_ex_read_data1  = r_ex_read_data1;
  assign o_ex_read_data2  = r_ex_read_data2;
  assign o_ex_sign_ext    = r_ex_sign_ext;
  assign o_ex_control     = r_ex_control;
  assign o_ex_valid       = r_ex_valid;
  assign o_hazard_stall   = w_hazard_stall;
  assign o_stall_count    = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0, id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_se = '0;
  logic [9:0]  id_ctrl = '0;
  logic        flush = 1'b0, ext = 1'b0;
  logic [31:0] ex_instr, ex_pc, ex_rd1, ex_rd2, ex_se;
  logic [9:0]  ex_ctrl;
  logic        ex_valid, hz_stall;
  logic [4:0]  ex_regdest;
  logic [15:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid), .i_id_instruction(id_instr),
    .i_id_pc_plus4(id_pc), .i_id_read_data1(id_rd1), .i_id_read_data2(id_rd2),
    .i_id_sign_ext(id_se), .i_id_control(id_ctrl), .i_flush(flush), .i_ext_stall(ext),
    .o_ex_instruction(ex_instr), .o_ex_pc_plus4(ex_pc), .o_ex_read_data1(ex_rd1),
    .o_ex_read_data2(ex_rd2), .o_ex_sign_ext(ex_se), .o_ex_control(ex_ctrl),
    .o_ex_valid(ex_valid), .o_ex_regdest(ex_regdest), .o_hazard_stall(hz_stall),
    .o_stall_count(stall_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] C_LW   = 10'b1_1_0_1_1_00_000;
  localparam logic [9:0] C_ADD  = 10'b1_0_0_0_0_01_010;
  localparam logic [9:0] C_ADDI = 10'b1_0_0_0_1_00_000;
  localparam logic [9:0] C_JAL  = 10'b1_0_0_0_0_10_000;
  localparam logic [9:0] C_R11  = 10'b1_0_0_0_0_11_010;
  localparam logic [9:0] C_SW   = 10'b0_0_1_0_1_01_000;

  // Reference EX-stage contents, advanced by the priority rules once per clock
  logic        m_valid;
  logic [9:0]  m_ctrl;
  logic [31:0] m_instr, m_pc, m_rd1, m_rd2, m_se;
  int          m_cnt;

  function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd);
    return (rs << 21) | (rt << 16) | (rd << 11) | 32'h20;
  endfunction

  function automatic logic [31:0] mk_i(input int op, input int rs, input int rt);
    return (op << 26) | (rs << 21) | (rt << 16) | 32'h0004;
  endfunction

  function automatic int m_dest();
    int sel;
    if (!m_valid || !m_ctrl[9]) return 0;
    sel = (m_ctrl >> 3) % 4;
    if (sel == 2) return 31;
    if (sel == 1) return (m_instr >> 11) % 32;
    return (m_instr >> 16) % 32;
  endfunction

  function automatic bit m_hazard();
    int d, rs, rt;
    d  = m_dest();
    rs = (id_instr >> 21) % 32;
    rt = (id_instr >> 16) % 32;
    return m_valid && m_ctrl[8] && d != 0 && id_valid && (d == rs || d == rt);
  endfunction

  task automatic m_reset();
    m_valid = 0; m_ctrl = 0; m_instr = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_se = 0; m_cnt = 0;
  endtask

  task automatic m_clock();
    bit hz;
    hz = m_hazard();
    if (hz && !flush && m_cnt < 65535) m_cnt++;
    if (flush) begin
      m_valid = 0; m_ctrl = 0; m_instr = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_se = 0;
    end else if (!ext) begin
      m_valid = hz ? 1'b0 : id_valid;
      m_ctrl  = (hz || !id_valid) ? 10'd0 : id_ctrl;
      m_instr = id_instr; m_pc = id_pc; m_rd1 = id_rd1; m_rd2 = id_rd2; m_se = id_se;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm);
    check({nm, ".valid"}, 32'(ex_valid), 32'(m_valid));
    check({nm, ".ctrl"},  32'(ex_ctrl), 32'(m_ctrl));
    check({nm, ".instr"}, ex_instr, m_instr);
    check({nm, ".pc"},    ex_pc, m_pc);
    check({nm, ".rd1"},   ex_rd1, m_rd1);
    check({nm, ".rd2"},   ex_rd2, m_rd2);
    check({nm, ".se"},    ex_se, m_se);
    check({nm, ".dest"},  32'(ex_regdest), 32'(m_dest()));
    check({nm, ".stall"}, 32'(hz_stall), 32'(m_hazard() && !flush));
    check({nm, ".count"}, 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [9:0] c,
                       input bit fl, input bit st);
    id_valid = v; id_instr = ins; id_ctrl = c; flush = fl; ext = st;
    id_pc = $urandom; id_rd1 = $urandom; id_rd2 = $urandom; id_se = $urandom;
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge
  task automatic step(input bit chk, input string nm);
    #1;
    if (chk) check_all(nm);
    @(posedge clk);
    m_clock();
    @(negedge clk);
  endtask

  typedef struct {
    logic        valid;
    logic [9:0]  ctrl;
    logic [31:0] instr;
    logic [4:0]  exp_dest;
  } dest_vec_t;

  dest_vec_t tbl[7];
  logic [31:0] lw8, add98, other;
  int          cnt_save;

  initial begin
    tbl[0] = '{1'b1, C_ADD,  mk_r(1, 2, 3),   5'd3};
    tbl[1] = '{1'b1, C_ADDI, mk_i(8, 4, 7),   5'd7};
    tbl[2] = '{1'b1, C_JAL,  mk_r(1, 2, 5),   5'd31};
    tbl[3] = '{1'b1, C_R11,  mk_r(1, 9, 12),  5'd9};
    tbl[4] = '{1'b1, C_SW,   mk_r(1, 2, 3),   5'd0};
    tbl[5] = '{1'b0, C_ADD,  mk_r(1, 2, 3),   5'd0};
    tbl[6] = '{1'b1, C_JAL,  mk_r(0, 0, 31),  5'd31};
    lw8   = mk_i(35, 29, 8);
    add98 = mk_r(8, 10, 9);
    other = mk_r(3, 4, 17);

    m_reset();
    drive(0, 0, 0, 0, 0);
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // LW $8 then dependent ADD: one bubble, one stall cycle
    drive(1, lw8, C_LW, 0, 0);
    step(1, "lw8");
    drive(1, add98, C_ADD, 0, 0);
    #1 check("lu.stall_hi", 32'(hz_stall), 32'd1);
    step(1, "lu.bubble");
    check("lu.bubble_valid", 32'(ex_valid), 32'd0);
    check("lu.count1", 32'(stall_cnt), 32'd1);
    #1 check("lu.stall_lo", 32'(hz_stall), 32'd0);
    step(1, "lu.add");
    check("lu.add_valid", 32'(ex_valid), 32'd1);
    check("lu.add_instr", ex_instr, add98);

    // LW $0 never creates a hazard
    drive(1, mk_i(35, 29, 0), C_LW, 0, 0);
    step(1, "lw0");
    drive(1, mk_r(0, 0, 11), C_ADD, 0, 0);
    #1 check("lw0.stall", 32'(hz_stall), 32'd0);
    step(1, "lw0.use");
    check("lw0.valid", 32'(ex_valid), 32'd1);

    // Hazard coinciding with flush
    drive(1, lw8, C_LW, 0, 0);
    step(1, "fl.lw8");
    cnt_save = stall_cnt;
    drive(1, add98, C_ADD, 1, 0);
    #1 check("fl.stall", 32'(hz_stall), 32'd0);
    step(1, "fl.edge");
    check("fl.valid", 32'(ex_valid), 32'd0);
    check("fl.instr", ex_instr, 32'd0);
    check("fl.count", 32'(stall_cnt), 32'(cnt_save));
    drive(1, add98, C_ADD, 0, 0);
    step(1, "fl.reload");
    check("fl.reload_valid", 32'(ex_valid), 32'd1);

    // Three cycles of external stall hold the ADD in EX
    for (int i = 0; i < 3; i++) begin
      drive(1, other, C_ADD, 0, 1);
      step(1, "ext.hold");
      check("ext.hold_instr", ex_instr, add98);
    end
    drive(1, other, C_ADD, 0, 0);
    step(1, "ext.release");
    check("ext.release_instr", ex_instr, other);

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].instr, tbl[i].ctrl, 0, 0);
      step(1, "tbl.load");
      check($sformatf("tbl[%0d].dest", i), 32'(ex_regdest), 32'(tbl[i].exp_dest));
    end

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0,
            mk_r($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
            10'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      step(1, "rnd");
    end

    // Hold a load-use pair under external stall long enough to saturate the counter
    drive(1, lw8, C_LW, 0, 0);
    step(1, "sat.lw8");
    drive(1, add98, C_ADD, 0, 1);
    for (int i = 0; i < 70000; i++) step(0, "sat");
    #1 check("sat.count", 32'(stall_cnt), 32'h0000FFFF);
    drive(1, add98, C_ADD, 0, 0);
    step(1, "sat.bubble");
    check("sat.count_hold", 32'(stall_cnt), 32'h0000FFFF);
    check("sat.bubble_valid", 32'(ex_valid), 32'd0);

    // Asynchronous reset in the middle of the bubble cycle
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check("rst.valid", 32'(ex_valid), 32'd0);
    check("rst.instr", ex_instr, 32'd0);
    check("rst.pc", ex_pc, 32'd0);
    check("rst.count", 32'(stall_cnt), 32'd0);
    check("rst.stall", 32'(hz_stall), 32'd0);
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, add98, C_ADD, 0, 0);
    step(1, "rst.load");
    check("rst.load_valid", 32'(ex_valid), 32'd1);
    check("rst.load_instr", ex_instr, add98);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
